// File: rtl/wb_pkg.sv
// Shared types for the register-file write-port arbiter: request payload and FSM state.
package wb_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

    typedef enum logic {
        NORM  = 1'b0,
        DRAIN = 1'b1
    } arb_state_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback-side bus of the arbiter: pipeline request, long-latency handshake and register-file port.
interface wb_port_arbiter_if;
    import wb_pkg::*;

    logic                  pipe_valid;
    logic [REG_ADDR_W-1:0] pipe_rd;
    logic [DATA_W-1:0]     pipe_data;
    logic                  pipe_stall;

    logic                  lat_valid;
    logic                  lat_ready;
    logic [REG_ADDR_W-1:0] lat_rd;
    logic [DATA_W-1:0]     lat_data;

    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0]     rf_data;

    modport master (
        output pipe_valid, pipe_rd, pipe_data, lat_valid, lat_rd, lat_data,
        input  pipe_stall, lat_ready, rf_we, rf_rd, rf_data
    );

    modport slave (
        input  pipe_valid, pipe_rd, pipe_data, lat_valid, lat_rd, lat_data,
        output pipe_stall, lat_ready, rf_we, rf_rd, rf_data
    );

endinterface

// File: rtl/wb_lat_fifo.sv
// Small synchronous FIFO holding long-latency results until a free write-port slot appears.
module wb_lat_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  wb_req_t          push_req,
    input  logic             pop,
    output wb_req_t          head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    wb_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // NOTE: storage has no reset; count/pointers alone decide validity, so the array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_req;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback and buffered long-latency results.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    wb_port_arbiter_if.slave bus
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    arb_state_t        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    wb_req_t           head;
    wb_req_t           lat_req;
    wb_req_t           grant_req;
    logic              grant;
    logic              push;
    logic              pop;
    logic              lat_hs;
    logic              to_drain;

    assign lat_req        = '{rd: bus.lat_rd, data: bus.lat_data};
    assign bus.lat_ready  = (count < CNT_W'(DEPTH)) && (state == NORM);
    assign bus.pipe_stall = (state == DRAIN);
    assign lat_hs         = bus.lat_valid && bus.lat_ready;

    wb_lat_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_req (lat_req),
        .pop      (pop),
        .head     (head),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant     = 1'b0;
        grant_req = '0;
        push      = 1'b0;
        pop       = 1'b0;
        if (state == DRAIN) begin
            grant     = 1'b1;
            grant_req = head;
            pop       = 1'b1;
        end else if (bus.pipe_valid) begin
            grant     = 1'b1;
            grant_req = '{rd: bus.pipe_rd, data: bus.pipe_data};
            push      = lat_hs;
        end else if (!empty) begin
            grant     = 1'b1;
            grant_req = head;
            pop       = 1'b1;
            push      = lat_hs;
        end else if (lat_hs) begin
            grant     = 1'b1;
            grant_req = lat_req;
        end
    end

    // Drain on a head blocked for MAX_WAIT cycles, or on a producer pushing into a full FIFO.
    assign to_drain = (!empty && !pop && wait_cnt == WAIT_W'(MAX_WAIT - 1))
                   || (full && bus.lat_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= NORM;
            wait_cnt    <= '0;
            bus.rf_we   <= 1'b0;
            bus.rf_rd   <= '0;
            bus.rf_data <= '0;
        end else begin
            bus.rf_we <= grant;
            if (grant) begin
                bus.rf_rd   <= grant_req.rd;
                bus.rf_data <= grant_req.data;
            end

            if (pop || empty)                        wait_cnt <= '0;
            else if (wait_cnt != WAIT_W'(MAX_WAIT))  wait_cnt <= wait_cnt + 1'b1;

            case (state)
                NORM:    if (to_drain) state <= DRAIN;
                DRAIN:   if (count == CNT_W'(1)) state <= NORM;
                default: state <= NORM;
            endcase
        end
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline writeback (output of the wb RegSrc mux) and a long-latency result source (multi-cycle mul/div, late memory return). Long-latency results are buffered in a small FIFO and written in pipeline bubbles. The pipeline is stalled only on starvation or FIFO overflow. Sits between the wb stage and the register file.

Parameters:
DATA_W, 16, register data width
REG_ADDR_W, 3, register index width (8 registers)
DEPTH, 2, long-latency FIFO entries (power of 2, >=2)
MAX_WAIT, 4, cycles a FIFO head may be blocked before a forced drain

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pipe_valid  in  1  pipeline writeback request (RegWrite)
pipe_rd  in  REG_ADDR_W  pipeline destination register
pipe_data  in  DATA_W  pipeline write data (data_to_write)
pipe_stall  out  1  freeze pipeline; combinational, equals (state==DRAIN)
lat_valid  in  1  long-latency result valid
lat_ready  out  1  result accepted when lat_valid&&lat_ready
lat_rd  in  REG_ADDR_W  long-latency destination
lat_data  in  DATA_W  long-latency data
rf_we  out  1  register-file write enable (registered)
rf_rd  out  REG_ADDR_W  write index (registered)
rf_data  out  DATA_W  write data (registered)

Behaviour:
- Reset (async, rst_n low): state=NORM, FIFO count=0, wait_cnt=0, rf_we=0, rf_rd=0, rf_data=0; pipe_stall=0, lat_ready=1.
- Reset mid-operation: buffered entries are discarded; no write is issued in the first cycle after deassertion.
- lat_ready = (count<DEPTH) && (state==NORM).
- Grant per cycle, NORM state, priority order:
  1. pipe_valid -> write pipe request; a concurrent lat handshake enqueues.
  2. else FIFO nonempty -> pop head and write it; a concurrent lat handshake enqueues behind it.
  3. else lat handshake with FIFO empty -> bypass: write lat request directly, no enqueue.
  4. else no write.
- DRAIN state: pipe_valid is ignored (the pipeline holds its request); pop head every cycle; no pushes.
- Latency: the granted request appears on rf_* at the next rising edge with rf_we=1. When there is no grant, rf_we=0 and rf_rd/rf_data hold their values.
- wait_cnt: cleared on a pop or while the FIFO is empty; +1 each cycle the FIFO is nonempty and the head is not popped; saturates.
- NORM->DRAIN at an edge when either condition holds:
  - wait_cnt==MAX_WAIT-1 and the head is not popped this cycle; or
  - count==DEPTH and lat_valid (overflow pressure).
- DRAIN->NORM at the edge where the pop leaves count==0; wait_cnt cleared. DRAIN lasts exactly the number of entries held at entry.
- Ordering: FIFO is strict FIFO; the bypass path is used only when the FIFO is empty, so lat results are written in arrival order. WAW hazards between pipe and lat are excluded by the issue scoreboard; the arbiter performs no rd compare.
- Count arithmetic: simultaneous push and pop leaves count unchanged; pointers wrap modulo DEPTH.

Decomposition:
- wb_pkg:
  - DATA_W/REG_ADDR_W defaults
  - wb_req_t struct {rd, data}
  - arb_state_t enum {NORM, DRAIN}
- Sub-module wb_lat_fifo: synchronous FIFO of wb_req_t.
  - Inputs: push, pop.
  - Outputs: head, count, full, empty.
  - Reset: async active-low.
- Arbiter FSM, wait counter and output registers live in wb_port_arbiter.

Test Plan:
- Reset: rst_n=0 mid-stream with 2 entries buffered -> rf_we=0, pipe_stall=0, lat_ready=1; no stale write after release.
- Pipe only: pipe_valid=1, rd=3, data=0x0004 -> next cycle rf_we=1, rf_rd=3, rf_data=0x0004.
- Bypass: pipe idle, lat rd=5, data=0xBEEF -> next cycle r5=0xBEEF; FIFO count stays 0.
- Collision: same cycle pipe r1=0x0001 and lat r2=0x0002, pipe idle afterwards -> writes r1 then r2 in consecutive cycles; pipe_stall never 1.
- Starvation: MAX_WAIT=4, pipe_valid held high, one lat push (r6=0x1234) -> head blocked 4 cycles, then pipe_stall=1 for exactly 1 cycle, r6=0x1234 written, then pipe writes resume in order.
- Overflow: DEPTH=2 filled (r1=0xA, r2=0xB), lat_valid held with r3=0xC under continuous pipe traffic:
  - Required response: DRAIN, lat_ready=0, pipe_stall=1 for 2 cycles, writes r1 then r2.
  - Then NORM; r3 accepted and written in arrival order.
